// File: rtl/tmr_scrubber.sv
// tmr_scrubber
//   Scrubs a bank of triplicated register bits. When start is seen in IDLE,
//   the scrubber votes on one bit per cycle. It reads copy_a/copy_b/copy_c at
//   the current index. When a triplicated bit has a disagreement, it raises a
//   valid/ready write-back request. That request carries the majority value
//   and the mask of disagreeing copies. The scrubber also keeps sticky
//   per-bit error flags and a saturating error count.
//
// Ports
//   clk, rstn          clock (rising edge), synchronous active-low reset
//   start              begin one full scan (only honoured in IDLE)
//   copy_a/b/c [W]     the three copies of every bank bit
//   wr_valid/wr_ready  write-back handshake
//   wr_idx [IDX_W]     bit index to repair
//   wr_val             majority value to write into all copies
//   wr_mask [3]        copies that disagreed, {c,b,a}
//   clr_err            clear err_cnt and err_bit (wins over a new detection)
//   busy               scan in progress (SCAN or FIX)
//   done               one-cycle pulse at the end of a scan
//   err_cnt [CNT_W]    saturating count of detected errors
//   err_bit [W]        sticky per-bit error flags
module tmr_scrubber #(
    parameter int              W          = 10,
    parameter logic [W-1:0]    TRIPLICATE = 10'b0101010101,
    parameter int              IDX_W      = 4,
    parameter int              CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [W-1:0]     copy_a,
    input  logic [W-1:0]     copy_b,
    input  logic [W-1:0]     copy_c,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [IDX_W-1:0] wr_idx,
    output logic             wr_val,
    output logic [2:0]       wr_mask,
    input  logic             clr_err,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W-1:0]     err_bit
);

    typedef enum logic [1:0] {IDLE, SCAN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] wr_idx_reg;
    logic             wr_val_reg;
    logic [2:0]       wr_mask_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [W-1:0]     err_bit_reg;

    logic       bit_a, bit_b, bit_c, maj, last, detect;
    logic [2:0] mism;

    always_comb begin
        bit_a  = copy_a[idx_reg];
        bit_b  = copy_b[idx_reg];
        bit_c  = copy_c[idx_reg];
        maj    = (bit_a & bit_b) | (bit_a & bit_c) | (bit_b & bit_c);
        mism   = {bit_c != maj, bit_b != maj, bit_a != maj};
        last   = (idx_reg == IDX_W'(W - 1));
        // Non-triplicated bits are skipped even if their copies differ.
        detect = (state_reg == SCAN) && TRIPLICATE[idx_reg] && (mism != 3'b000);
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        busy       = 1'b0;
        done       = 1'b0;
        wr_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    idx_next   = '0;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (detect) begin
                    state_next = FIX;
                end else if (last) begin
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            FIX: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                // The repaired bit is not revisited; move past it on acceptance.
                if (wr_ready) begin
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        state_next = SCAN;
                        idx_next   = idx_reg + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Write-back payload is captured once at detection and frozen through FIX,
    // so changes on copy_* during the handshake cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_idx_reg  <= '0;
            wr_val_reg  <= 1'b0;
            wr_mask_reg <= 3'b000;
        end else if (detect) begin
            wr_idx_reg  <= idx_reg;
            wr_val_reg  <= maj;
            wr_mask_reg <= mism;
        end
    end

    // Error status. A clear in the same cycle as a detection discards that error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt_reg <= '0;
            err_bit_reg <= '0;
        end else if (clr_err) begin
            err_cnt_reg <= '0;
            err_bit_reg <= '0;
        end else if (detect) begin
            err_bit_reg[idx_reg] <= 1'b1;
            if (err_cnt_reg != {CNT_W{1'b1}}) begin
                err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign wr_idx  = wr_idx_reg;
    assign wr_val  = wr_val_reg;
    assign wr_mask = wr_mask_reg;
    assign err_cnt = err_cnt_reg;
    assign err_bit = err_bit_reg;

endmodule
